// File: rtl/im_load_ctrl.sv
// Boot-time loader for the instruction memory write port; holds the CPU while a program streams in.
// Optional trailing checksum word is enabled by defining IM_LOAD_CHECKSUM_EN.
module im_load_ctrl #(
  parameter int unsigned DEPTH     = 32,
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int unsigned LEN_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             im_in_enable,
  output logic [31:0]      im_in,
  output logic [63:0]      im_in_addr,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef IM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StDone, StErr} state_e;
  logic [31:0] sum_q;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StDone, StErr} state_e;
`endif

  localparam logic [LEN_W-1:0] CntOne = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             s_ready_q;
  logic             hs;

  // Reset gates s_ready so no write can slip through during the reset cycle.
  assign s_ready      = s_ready_q & ~rst;
  assign hs           = s_valid & s_ready;
  assign im_in_enable = hs & (state_q == StLoad);
  assign im_in        = im_in_enable ? s_data : 32'd0;
  assign im_in_addr   = BASE_ADDR + 64'({cnt_q, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      s_ready_q <= 1'b0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef IM_LOAD_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            cnt_q <= '0;
`ifdef IM_LOAD_CHECKSUM_EN
            sum_q <= '0;
`endif
            if (load_len == '0) begin
              state_q  <= StDone;
              done     <= 1'b1;
              err      <= 1'b0;
              cpu_hold <= 1'b0;
            end else if (32'(load_len) > DEPTH) begin
              state_q  <= StErr;
              done     <= 1'b0;
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              state_q   <= StLoad;
              len_q     <= load_len;
              done      <= 1'b0;
              err       <= 1'b0;
              cpu_hold  <= 1'b1;
              busy      <= 1'b1;
              s_ready_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (hs) begin
            cnt_q <= cnt_q + CntOne;
`ifdef IM_LOAD_CHECKSUM_EN
            sum_q <= sum_q + s_data;
            if (cnt_q == len_q - CntOne) begin
              state_q <= StCheck;
            end
`else
            if (cnt_q == len_q - CntOne) begin
              state_q   <= StDone;
              s_ready_q <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_hold  <= 1'b0;
            end
`endif
          end
        end
`ifdef IM_LOAD_CHECKSUM_EN
        StCheck: begin
          if (hs) begin
            s_ready_q <= 1'b0;
            busy      <= 1'b0;
            if (s_data == sum_q) begin
              state_q  <= StDone;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_q <= StErr;
              err     <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_im_load_ctrl.sv
// Self-checking bench for im_load_ctrl: directed test-plan steps plus randomized loads
// checked against a word-index/address model of the loader.
module tb_im_load_ctrl;
  localparam int unsigned DEPTH = 32;
  localparam logic [63:0] BASE  = 64'h0;
  localparam int          LEN_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] load_len = '0;
  logic             s_valid = 1'b0;
  logic [31:0]      s_data = '0;
  logic             s_ready;
  logic             im_in_enable;
  logic [31:0]      im_in;
  logic [63:0]      im_in_addr;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog [64];

  im_load_ctrl #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .LEN_W     (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .load_len     (load_len),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .im_in_enable (im_in_enable),
    .im_in        (im_in),
    .im_in_addr   (im_in_addr),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load transaction: n words from prog[], random gaps of gap_pct percent plus a forced
  // gap of gap_len cycles before word gap_at; optional start pulses during the load.
  task automatic load(input int n, input int gap_pct, input int gap_at, input int gap_len,
                      input bit bad_sum, input bit mid_start);
    int          i = 0;
    int          cycles = 0;
    int          gap_left;
    bit          v;
    bit          exp_err;
    logic [31:0] sum = 32'd0;
    gap_left = gap_len;
    start    = 1'b1;
    load_len = n[LEN_W-1:0];
    tick();
    start = 1'b0;
    if (n > 0 && n <= int'(DEPTH)) begin
      while (i < n && cycles < 20 * n + 50) begin
        if (i == gap_at && gap_left > 0) begin
          v = 1'b0;
          gap_left--;
        end else begin
          v = ($urandom_range(99) >= gap_pct);
        end
        s_valid  = v;
        s_data   = v ? prog[i] : $urandom();
        start    = mid_start && (i == 3);
        load_len = LEN_W'($urandom());
        @(negedge clk);
        chk("busy_load", busy, 1);
        chk("hold_load", cpu_hold, 1);
        chk("ready_load", s_ready, 1);
        chk("wr_en", im_in_enable, v);
        if (v) begin
          chk("wr_data", im_in, prog[i]);
          chk("wr_addr", im_in_addr, BASE + 64'(i) * 64'd4);
          sum += prog[i];
          i++;
        end else begin
          chk("idle_data", im_in, 0);
        end
        @(posedge clk);
        #1;
        cycles++;
      end
      start   = 1'b0;
      s_valid = 1'b0;
      if (i < n) chk("load_timeout", i, n);
`ifdef IM_LOAD_CHECKSUM_EN
      s_valid = 1'b1;
      s_data  = sum + (bad_sum ? 32'd1 : 32'd0);
      @(negedge clk);
      chk("chk_no_write", im_in_enable, 0);
      chk("chk_ready", s_ready, 1);
      chk("chk_busy", busy, 1);
      tick();
      s_valid = 1'b0;
`endif
    end
    exp_err = (n > int'(DEPTH));
`ifdef IM_LOAD_CHECKSUM_EN
    if (n > 0 && n <= int'(DEPTH) && bad_sum) exp_err = 1'b1;
`endif
    @(negedge clk);
    chk("done_end", done, !exp_err);
    chk("err_end", err, exp_err);
    chk("hold_end", cpu_hold, exp_err);
    chk("busy_end", busy, 0);
    chk("ready_end", s_ready, 0);
    chk("wr_en_end", im_in_enable, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset values
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_wr_en", im_in_enable, 0);
    chk("rst_data", im_in, 0);
    chk("rst_addr", im_in_addr, BASE);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();

    // Four-word program, continuous valid
    prog[0] = 32'h00500093;
    prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h00000013;
    load(4, 0, -1, 0, 1'b0, 1'b0);

    // Three words with a two-cycle stall before word 2
    load(3, 0, 2, 2, 1'b0, 1'b0);

    // Oversized length, then zero length
    load(33, 0, -1, 0, 1'b0, 1'b0);
    load(0, 0, -1, 0, 1'b0, 1'b0);

    // Reset after two of five words
    for (int k = 0; k < 5; k++) prog[k] = $urandom();
    start    = 1'b1;
    load_len = LEN_W'(5);
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = prog[0];
    tick();
    s_data = prog[1];
    tick();
    rst    = 1'b1;
    s_data = prog[2];
    @(negedge clk);
    chk("midrst_no_write", im_in_enable, 0);
    chk("midrst_ready", s_ready, 0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_hold", cpu_hold, 1);
    chk("midrst_addr", im_in_addr, BASE);
    chk("midrst_done", done, 0);
    tick();
    load(5, 0, -1, 0, 1'b0, 1'b0);

`ifdef IM_LOAD_CHECKSUM_EN
    prog[0] = 32'd1;
    prog[1] = 32'd2;
    prog[2] = 32'd3;
    load(3, 0, -1, 0, 1'b0, 1'b0);
    load(3, 0, -1, 0, 1'b1, 1'b0);
`endif

    // Start pulses during an eight-word load are ignored
    for (int k = 0; k < 8; k++) prog[k] = $urandom();
    load(8, 0, -1, 0, 1'b0, 1'b1);

    // Randomized loads
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(40);
      for (int k = 0; k < 40; k++) prog[k] = $urandom();
      load(n, 25, $urandom_range(7), $urandom_range(3), bit'($urandom_range(1)),
           bit'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
